// File: rtl/next_pulse_gen_pkg.sv
// next_pulse_gen shared types: FSM state encoding and phase timer sizing.
// Used by next_pulse_gen and pulse_phase_timer.
package next_pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int timer_width(
      input int h,
      input int l
   );
      int m;
      m = (h > l) ? h : l;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

   localparam int DEF_TIMER_W = timer_width(1, 1);

endpackage

// File: rtl/next_pulse_gen_timer.sv
// pulse_phase_timer: loadable down-counter, expire flags the last cycle
// of a phase so the FSM can move on at the following edge.
module pulse_phase_timer
   import next_pulse_gen_pkg::*;
#(
   parameter int W = DEF_TIMER_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == W'(1));

endmodule

// File: rtl/next_pulse_gen.sv
// next_pulse_gen: bursts of clean next strobes with start/busy/done.
// Define NEXT_PULSE_GEN_CHECK_EN to compare counter readback per burst.
module next_pulse_gen
   import next_pulse_gen_pkg::*;
#(
   parameter int COUNT_WIDTH = 8,
   parameter int HIGH_CYCLES = 1,
   parameter int LOW_CYCLES  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [COUNT_WIDTH-1:0] num_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   output logic                   next_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [COUNT_WIDTH-1:0] sent_o,
   output logic                   err_o
);

   localparam int TW = timer_width(HIGH_CYCLES, LOW_CYCLES);

   state_t                 state;
   logic [COUNT_WIDTH-1:0] num_q;
   logic [COUNT_WIDTH-1:0] sent_q;
   logic                   accept;
   logic                   last;
   logic                   t_load;
   logic                   t_exp;
   logic [TW-1:0]          t_val;

   assign accept = (state == IDLE) && start_i;
   assign last   = (sent_q == num_q);

   always_comb begin
      t_load = 1'b0;
      t_val  = TW'(HIGH_CYCLES);
      unique case (1'b1)
         (state == IDLE): t_load = start_i && (num_i != '0);
         (state == HIGH): begin
            t_load = t_exp;
            t_val  = TW'(LOW_CYCLES);
         end
         (state == LOW):  t_load = t_exp && !last;
         default:         t_load = 1'b0;
      endcase
   end

   pulse_phase_timer #(
      .W(TW)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (t_load),
      .load_val(t_val),
      .expire  (t_exp)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         num_q  <= '0;
         sent_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  num_q  <= num_i;
                  sent_q <= '0;
                  state  <= (num_i != '0) ? HIGH : DONE;
               end
            end
            HIGH: begin
               if (t_exp) begin
                  sent_q <= sent_q + 1'b1;
                  state  <= LOW;
               end
            end
            LOW: begin
               if (t_exp) begin
                  state <= last ? DONE : HIGH;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode only the state register, never the inputs.
   assign next_o = (state == HIGH);
   assign busy_o = (state != IDLE);
   assign done_o = (state == DONE);
   assign sent_o = sent_q;

`ifdef NEXT_PULSE_GEN_CHECK_EN
   logic [COUNT_WIDTH-1:0] base_q;
   logic [COUNT_WIDTH-1:0] diff;
   logic                   err_q;

   // Modular difference tolerates the counter wrapping mid-burst.
   assign diff = count_i - base_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         base_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         base_q <= count_i;
         err_q  <= 1'b0;
      end else if (done_o && (diff != num_q)) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_count;
   assign unused_count = ^count_i;
   assign err_o        = 1'b0;
`endif

endmodule
